// File: rtl/control_unit_param.sv
// Parametrised control unit with a 16-bit instruction, a 16-entry register file, an SRAM port and GPIO channels.
// Optional macro CU_SRAM_WAIT_EN adds a MEM_WAIT state that stalls LOAD/STORE until sram_ack.
module control_unit_param #(
    parameter int DATA_W  = 8,
    parameter int PC_W    = 12,
    parameter int GPIO_CH = 2
) (
    input  logic                      clk,
    input  logic                      arst,
    input  logic [15:0]               instruction,
    input  logic [DATA_W-1:0]         sram_read_data,
    input  logic                      sram_ack,
    input  logic [DATA_W-1:0]         alu_result,
    input  logic                      equal,
    input  logic                      carry_out,
    input  logic [GPIO_CH*DATA_W-1:0] in_gpio,
    input  logic                      bootstrapping,
    output logic [2:0]                alu_opcode,
    output logic [DATA_W-1:0]         alu_a,
    output logic [DATA_W-1:0]         alu_b,
    output logic                      sram_write_en,
    output logic                      sram_read_en,
    output logic [7:0]                sram_addr,
    output logic [DATA_W-1:0]         sram_write_data,
    output logic                      pc_load,
    output logic [PC_W-1:0]           pc_next,
    output logic                      pc_inc,
    output logic [GPIO_CH*DATA_W-1:0] out_gpio,
    output logic [GPIO_CH-1:0]        out_valid,
    output logic [1:0]                state
);
    typedef enum logic [1:0] {FETCH = 2'b00, EXECUTE = 2'b01, MEM_WAIT = 2'b10} state_t;

    localparam logic [3:0] OP_LOAD  = 4'd1;
    localparam logic [3:0] OP_STORE = 4'd2;
    localparam logic [3:0] OP_JMP   = 4'd3;
    localparam logic [3:0] OP_BEQ   = 4'd4;
    localparam logic [3:0] OP_BC    = 4'd5;
    localparam logic [3:0] OP_IN    = 4'd6;
    localparam logic [3:0] OP_OUT   = 4'd7;

    state_t                    state_q;
    logic [3:0]                op_q, dst_q, ra_q, rb_q;
    logic [DATA_W-1:0]         regs_q [16];
    logic [2:0]                alu_op_q;
    logic [DATA_W-1:0]         alu_a_q, alu_b_q;
    logic [GPIO_CH*DATA_W-1:0] out_gpio_q;
    logic [GPIO_CH-1:0]        out_valid_q;

    logic                      mem_done;
    logic                      in_exec;
    logic                      taken;
    logic [DATA_W-1:0]         in_sel;
    logic [DATA_W-1:0]         in_data;

`ifdef CU_SRAM_WAIT_EN
    assign mem_done = sram_ack;
`else
    logic unused_sram_ack;
    assign unused_sram_ack = sram_ack;
    assign mem_done        = 1'b1;
`endif

    // Handshake: the SRAM strobe, address and write data are asserted in EXECUTE and held
    // unchanged through MEM_WAIT; the access completes on the first cycle sram_ack is high.
    assign in_exec = (state_q == EXECUTE) || (state_q == MEM_WAIT);

    always_comb begin
        in_sel = '0;
        for (int k = 0; k < GPIO_CH; k++) begin
            if (int'(rb_q) == k) in_sel = in_gpio[k*DATA_W +: DATA_W];
        end
    end

    assign in_data = bootstrapping ? DATA_W'({ra_q, rb_q}) : in_sel;

    always_comb begin
        case (op_q)
            OP_JMP:  taken = 1'b1;
            OP_BEQ:  taken = equal;
            OP_BC:   taken = carry_out;
            default: taken = 1'b0;
        endcase
    end

    assign state           = state_q;
    assign pc_inc          = (state_q == FETCH);
    assign pc_load         = (state_q == EXECUTE) && taken;
    assign pc_next         = PC_W'({dst_q, ra_q, rb_q});
    assign sram_addr       = {ra_q, rb_q};
    assign sram_read_en    = in_exec && (op_q == OP_LOAD);
    assign sram_write_en   = in_exec && (op_q == OP_STORE);
    assign sram_write_data = sram_write_en ? regs_q[dst_q] : '0;
    assign alu_opcode      = alu_op_q;
    assign alu_a           = alu_a_q;
    assign alu_b           = alu_b_q;
    assign out_gpio        = out_gpio_q;
    assign out_valid       = out_valid_q;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q     <= FETCH;
            op_q        <= '0;
            dst_q       <= '0;
            ra_q        <= '0;
            rb_q        <= '0;
            alu_op_q    <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            out_gpio_q  <= '0;
            out_valid_q <= '0;
            for (int i = 0; i < 16; i++) regs_q[i] <= '0;
        end else begin
            out_valid_q <= '0;
            case (state_q)
                FETCH: begin
                    op_q     <= instruction[15:12];
                    dst_q    <= instruction[11:8];
                    ra_q     <= instruction[7:4];
                    rb_q     <= instruction[3:0];
                    alu_op_q <= instruction[14:12];
                    alu_a_q  <= regs_q[instruction[7:4]];
                    alu_b_q  <= regs_q[instruction[3:0]];
                    state_q  <= EXECUTE;
                end
                EXECUTE: begin
                    state_q <= FETCH;
                    case (op_q)
                        OP_LOAD: begin
                            if (mem_done) regs_q[dst_q] <= sram_read_data;
                            else          state_q       <= MEM_WAIT;
                        end
                        OP_STORE: begin
                            if (!mem_done) state_q <= MEM_WAIT;
                        end
                        OP_IN: regs_q[dst_q] <= in_data;
                        OP_OUT: begin
                            // Channel numbers beyond GPIO_CH match no k and leave outputs untouched.
                            for (int k = 0; k < GPIO_CH; k++) begin
                                if (int'(rb_q) == k) begin
                                    out_gpio_q[k*DATA_W +: DATA_W] <= regs_q[dst_q];
                                    out_valid_q[k]                 <= 1'b1;
                                end
                            end
                        end
                        default: begin
                            if (op_q[3]) regs_q[dst_q] <= alu_result;
                        end
                    endcase
                end
                MEM_WAIT: begin
                    if (mem_done) begin
                        if (op_q == OP_LOAD) regs_q[dst_q] <= sram_read_data;
                        state_q <= FETCH;
                    end
                end
                default: state_q <= FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_control_unit_param.sv
// Bench for control_unit_param: an instruction-level model drives per-cycle expectations
// checked on every falling edge, plus literal checks of the documented scenarios.
module tb_control_unit_param;
    localparam int DW = 8;
    localparam int PW = 12;
    localparam int CH = 2;

    logic            clk = 1'b0;
    logic            arst;
    logic [15:0]     instruction;
    logic [DW-1:0]   sram_read_data;
    logic            sram_ack;
    logic [DW-1:0]   alu_result;
    logic            equal;
    logic            carry_out;
    logic [CH*DW-1:0] in_gpio;
    logic            bootstrapping;
    logic [2:0]      alu_opcode;
    logic [DW-1:0]   alu_a, alu_b;
    logic            sram_write_en, sram_read_en;
    logic [7:0]      sram_addr;
    logic [DW-1:0]   sram_write_data;
    logic            pc_load;
    logic [PW-1:0]   pc_next;
    logic            pc_inc;
    logic [CH*DW-1:0] out_gpio;
    logic [CH-1:0]   out_valid;
    logic [1:0]      state;

    control_unit_param #(.DATA_W(DW), .PC_W(PW), .GPIO_CH(CH)) dut (
        .clk(clk), .arst(arst), .instruction(instruction), .sram_read_data(sram_read_data),
        .sram_ack(sram_ack), .alu_result(alu_result), .equal(equal), .carry_out(carry_out),
        .in_gpio(in_gpio), .bootstrapping(bootstrapping), .alu_opcode(alu_opcode),
        .alu_a(alu_a), .alu_b(alu_b), .sram_write_en(sram_write_en), .sram_read_en(sram_read_en),
        .sram_addr(sram_addr), .sram_write_data(sram_write_data), .pc_load(pc_load),
        .pc_next(pc_next), .pc_inc(pc_inc), .out_gpio(out_gpio), .out_valid(out_valid),
        .state(state)
    );

    always #5 clk = ~clk;

    // Instruction-level model state.
    logic [DW-1:0] m_regs [16];
    logic [DW-1:0] m_out  [CH];
    logic [DW-1:0] m_in   [CH];
    logic [CH-1:0] pend_valid;

    // Per-cycle expectations.
    logic          chk_on;
    logic          exp_exec;
    logic [1:0]    exp_state;
    logic          exp_pc_inc, exp_pc_load, exp_rd, exp_wr;
    logic [PW-1:0] exp_pc_next;
    logic [7:0]    exp_addr;
    logic [DW-1:0] exp_wdata, exp_alu_a, exp_alu_b;
    logic [2:0]    exp_alu_op;
    logic [CH-1:0] exp_out_valid;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [CH*DW-1:0] pack_out();
        logic [CH*DW-1:0] v;
        for (int k = 0; k < CH; k++) v[k*DW +: DW] = m_out[k];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = '0;
        for (int k = 0; k < CH; k++) m_out[k] = '0;
        pend_valid = '0;
    endtask

    task automatic set_gpio(input logic [DW-1:0] c0, input logic [DW-1:0] c1);
        m_in[0] = c0;
        m_in[1] = c1;
        in_gpio = {c1, c0};
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("state", 32'(state), 32'(exp_state));
            chk("pc_inc", 32'(pc_inc), 32'(exp_pc_inc));
            chk("pc_load", 32'(pc_load), 32'(exp_pc_load));
            chk("sram_read_en", 32'(sram_read_en), 32'(exp_rd));
            chk("sram_write_en", 32'(sram_write_en), 32'(exp_wr));
            chk("out_valid", 32'(out_valid), 32'(exp_out_valid));
            chk("out_gpio", 32'(out_gpio), 32'(pack_out()));
            if (exp_exec) begin
                chk("alu_a", 32'(alu_a), 32'(exp_alu_a));
                chk("alu_b", 32'(alu_b), 32'(exp_alu_b));
                chk("alu_opcode", 32'(alu_opcode), 32'(exp_alu_op));
                chk("sram_addr", 32'(sram_addr), 32'(exp_addr));
                chk("sram_write_data", 32'(sram_write_data), 32'(exp_wdata));
            end
            if (exp_pc_load) chk("pc_next", 32'(pc_next), 32'(exp_pc_next));
        end
    end

    // Starts at the beginning of a FETCH cycle, returns at its falling edge.
    task automatic fetch_phase(input logic [15:0] ins);
        instruction   = ins;
        exp_exec      = 1'b0;
        exp_state     = 2'b00;
        exp_pc_inc    = 1'b1;
        exp_pc_load   = 1'b0;
        exp_rd        = 1'b0;
        exp_wr        = 1'b0;
        exp_out_valid = pend_valid;
        pend_valid    = '0;
        @(negedge clk);
    endtask

    task automatic exec_phase(input logic [15:0] ins, input logic eq_v, input logic cy_v,
                              input logic [DW-1:0] res_v, input logic [DW-1:0] rdata_v,
                              input logic ack_v);
        int op, d, a, b;
        op = int'(ins[15:12]);
        d  = int'(ins[11:8]);
        a  = int'(ins[7:4]);
        b  = int'(ins[3:0]);
        @(posedge clk);
        #1;
        instruction    = 16'($urandom);
        equal          = eq_v;
        carry_out      = cy_v;
        alu_result     = res_v;
        sram_read_data = rdata_v;
        sram_ack       = ack_v;
        exp_exec       = 1'b1;
        exp_state      = 2'b01;
        exp_pc_inc     = 1'b0;
        exp_alu_a      = m_regs[a];
        exp_alu_b      = m_regs[b];
        exp_alu_op     = ins[14:12];
        exp_addr       = ins[7:0];
        exp_rd         = (op == 1);
        exp_wr         = (op == 2);
        exp_wdata      = (op == 2) ? m_regs[d] : '0;
        exp_pc_load    = (op == 3) || (op == 4 && eq_v) || (op == 5 && cy_v);
        exp_pc_next    = PW'(ins[11:0]);
        exp_out_valid  = '0;
        @(negedge clk);
    endtask

    task automatic commit_phase(input logic [15:0] ins, input logic [DW-1:0] res_v,
                                input logic [DW-1:0] rdata_v);
        int op, d, b;
        op = int'(ins[15:12]);
        d  = int'(ins[11:8]);
        b  = int'(ins[3:0]);
        @(posedge clk);
        #1;
        if (op == 1) m_regs[d] = rdata_v;
        else if (op == 6) m_regs[d] = bootstrapping ? DW'(ins[7:0]) : ((b < CH) ? m_in[b] : '0);
        else if (op == 7 && b < CH) begin
            m_out[b]      = m_regs[d];
            pend_valid[b] = 1'b1;
        end
        else if (op >= 8) m_regs[d] = res_v;
        sram_ack = 1'b0;
    endtask

    task automatic run_instr(input logic [15:0] ins, input logic eq_v, input logic cy_v,
                             input logic [DW-1:0] res_v, input logic [DW-1:0] rdata_v,
                             input logic ack_v);
        fetch_phase(ins);
        exec_phase(ins, eq_v, cy_v, res_v, rdata_v, ack_v);
        commit_phase(ins, res_v, rdata_v);
    endtask

    initial begin
        instruction = '0; sram_read_data = '0; sram_ack = 1'b0; alu_result = '0;
        equal = 1'b0; carry_out = 1'b0; bootstrapping = 1'b0; arst = 1'b1;
        chk_on = 1'b0;
        model_reset();
        set_gpio(8'h00, 8'h00);

        // Reset values
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_state", 32'(state), 32'h0);
        chk("rst_pc_load", 32'(pc_load), 32'h0);
        chk("rst_strobes", 32'({sram_read_en, sram_write_en}), 32'h0);
        chk("rst_out_gpio", 32'(out_gpio), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_alu_a", 32'(alu_a), 32'h0);
        @(posedge clk); #1;
        arst = 1'b0;
        chk_on = 1'b1;

        // IN with bootstrapping, then read back through alu_a
        bootstrapping = 1'b1;
        run_instr(16'h6312, 0, 0, 8'h00, 8'h00, 0);
        bootstrapping = 1'b0;
        fetch_phase(16'h8030);
        exec_phase(16'h8030, 0, 0, 8'h33, 8'h00, 0);
        chk("lit_boot_alu_a", 32'(alu_a), 32'h12);
        chk("lit_alu_opcode", 32'(alu_opcode), 32'h0);
        commit_phase(16'h8030, 8'h33, 8'h00);

        // GPIO in/out
        set_gpio(8'h3C, 8'hA5);
        run_instr(16'h6401, 0, 0, 8'h00, 8'h00, 0);
        run_instr(16'h7401, 0, 0, 8'h00, 8'h00, 0);
        fetch_phase(16'h0000);
        chk("lit_out_valid_strobe", 32'(out_valid), 32'h2);
        chk("lit_out_gpio_ch1", 32'(out_gpio[15:8]), 32'hA5);
        exec_phase(16'h0000, 0, 0, 8'h00, 8'h00, 0);
        chk("lit_out_valid_clear", 32'(out_valid), 32'h0);
        chk("lit_out_gpio_hold", 32'(out_gpio[15:8]), 32'hA5);
        commit_phase(16'h0000, 8'h00, 8'h00);
        run_instr(16'h6500, 0, 0, 8'h00, 8'h00, 0);
        bootstrapping = 1'b1;
        run_instr(16'h667E, 0, 0, 8'h00, 8'h00, 0);
        bootstrapping = 1'b0;
        run_instr(16'h6609, 0, 0, 8'h00, 8'h00, 0);
        run_instr(16'h7405, 0, 0, 8'h00, 8'h00, 0);
        run_instr(16'h7500, 0, 0, 8'h00, 8'h00, 0);
        run_instr(16'h0000, 0, 0, 8'h00, 8'h00, 0);
        chk("lit_out_gpio_both", 32'(out_gpio), 32'hA53C);

        // Branches and jumps
        fetch_phase(16'h4ABC);
        exec_phase(16'h4ABC, 1, 0, 8'h00, 8'h00, 0);
        chk("lit_beq_load", 32'(pc_load), 32'h1);
        chk("lit_beq_target", 32'(pc_next), 32'hABC);
        commit_phase(16'h4ABC, 8'h00, 8'h00);
        run_instr(16'h4ABC, 0, 1, 8'h00, 8'h00, 0);
        run_instr(16'h5123, 0, 1, 8'h00, 8'h00, 0);
        run_instr(16'h5123, 1, 0, 8'h00, 8'h00, 0);
        run_instr(16'h3FFF, 0, 0, 8'h00, 8'h00, 0);

        // ALU write then STORE of that register
        run_instr(16'h9123, 0, 0, 8'hC7, 8'h00, 0);
        fetch_phase(16'h2100);
        exec_phase(16'h2100, 0, 0, 8'h00, 8'h00, 1);
        chk("lit_store_data", 32'(sram_write_data), 32'hC7);
        commit_phase(16'h2100, 8'h00, 8'h00);

        // LOAD r2 from 0x40
`ifdef CU_SRAM_WAIT_EN
        fetch_phase(16'h1240);
        exec_phase(16'h1240, 0, 0, 8'h00, 8'h11, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            sram_ack       = (i == 2);
            sram_read_data = (i == 2) ? 8'h5A : 8'h11;
            exp_state      = 2'b10;
            @(negedge clk);
            chk("lit_wait_state", 32'(state), 32'h2);
            chk("lit_wait_addr", 32'(sram_addr), 32'h40);
        end
        commit_phase(16'h1240, 8'h00, 8'h5A);
`else
        run_instr(16'h1240, 0, 0, 8'h00, 8'h5A, 0);
`endif
        fetch_phase(16'hA020);
        exec_phase(16'hA020, 0, 0, 8'h01, 8'h00, 0);
        chk("lit_load_r2", 32'(alu_a), 32'h5A);
        commit_phase(16'hA020, 8'h01, 8'h00);

        // Reset in the middle of a LOAD aborts it
        fetch_phase(16'h1740);
        exec_phase(16'h1740, 0, 0, 8'h00, 8'h99, 0);
`ifdef CU_SRAM_WAIT_EN
        @(posedge clk); #1;
        exp_state = 2'b10;
        @(negedge clk);
`endif
        #1;
        chk_on = 1'b0;
        arst = 1'b1;
        #1;
        chk("lit_abort_state", 32'(state), 32'h0);
        chk("lit_abort_strobes", 32'({sram_read_en, sram_write_en, pc_load}), 32'h0);
        chk("lit_abort_out_gpio", 32'(out_gpio), 32'h0);
        model_reset();
        @(posedge clk); #1;
        arst = 1'b0;
        chk_on = 1'b1;
        fetch_phase(16'h8070);
        exec_phase(16'h8070, 0, 0, 8'h00, 8'h00, 0);
        chk("lit_abort_r7", 32'(alu_a), 32'h0);
        commit_phase(16'h8070, 8'h00, 8'h00);

        chk_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
